// File: rtl/uart_cmd_decoder_if.sv
// Byte stream from the UART receiver: one data byte qualified by a single-cycle done strobe.
interface uart_cmd_decoder_if;
    logic [7:0] data_i;
    logic       rx_done_tick_i;

    modport master (output data_i, output rx_done_tick_i);
    modport slave  (input  data_i, input  rx_done_tick_i);
endinterface

// File: rtl/uart_cmd_decoder.sv
// Assembles multi-byte UART commands (PERIOD/FREQ/DATA/CTRL) into channel settings.
// Optional trailing XOR checksum byte per command when DECODER_CHECKSUM_EN is defined.
module uart_cmd_decoder #(
    parameter int         DATA_BIT    = 32,
    parameter int         CH_NUM      = 16,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] CMD_DATA    = 8'h01,
    parameter logic [7:0] CMD_FREQ    = 8'h02,
    parameter logic [7:0] CMD_PERIOD  = 8'h03,
    parameter logic [7:0] CMD_CTRL    = 8'h04,
    localparam int        SEL_W       = $clog2(CH_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    uart_cmd_decoder_if.slave    rx_if,
    output logic [DATA_BIT-1:0]  output_pattern_o,
    output logic [DATA_BIT-1:0]  freq_pattern_o,
    output logic [SEL_W-1:0]     sel_out_o,
    output logic                 broadcast_o,
    output logic                 mode_o,
    output logic                 enable_o,
    output logic                 stop_o,
    output logic [7:0]           slow_period_o,
    output logic [7:0]           fast_period_o,
    output logic [7:0]           cmd_o,
    output logic                 done_tick_o,
    output logic                 err_tick_o,
    output logic [2:0]           err_code_o
);

    localparam int PAYLOAD_BYTES = DATA_BIT / 8;
    localparam int MAX_LEN       = PAYLOAD_BYTES + 1;
    localparam int CNT_W         = $clog2(MAX_LEN);
    localparam int TMO_W         = $clog2(TIMEOUT_CYC + 1);

`ifdef DECODER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD} state_t;
`endif

    state_t                r_state, w_state_next;
    logic [7:0]            r_cmd;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_last;
    logic [TMO_W-1:0]      r_tmo;
    logic [7:0]            r_buf [MAX_LEN];
`ifdef DECODER_CHECKSUM_EN
    logic [7:0]            r_xor;
`endif

    logic                  w_tick;
    logic                  w_known;
    logic                  w_tmo_hit;
    logic [7:0]            w_bytes [MAX_LEN];
    logic [7:0]            w_ch;
    logic                  w_ch_in_range;
    logic                  w_ch_ok;
    logic [DATA_BIT-1:0]   w_freq;
    logic [DATA_BIT-1:0]   w_dpat;
    logic                  w_apply;
    logic                  w_err;
    logic [2:0]            w_err_code;

    // Index of the final payload byte for each command code.
    function automatic logic [CNT_W-1:0] payload_last(input logic [7:0] code);
        logic [CNT_W-1:0] last;
        last = '0;
        if (code == CMD_PERIOD || code == CMD_CTRL) last = CNT_W'(1);
        else if (code == CMD_FREQ)                  last = CNT_W'(PAYLOAD_BYTES - 1);
        else if (code == CMD_DATA)                  last = CNT_W'(PAYLOAD_BYTES);
        return last;
    endfunction

    assign w_tick    = rx_if.rx_done_tick_i;
    assign w_known   = (rx_if.data_i == CMD_DATA) || (rx_if.data_i == CMD_FREQ) ||
                       (rx_if.data_i == CMD_PERIOD) || (rx_if.data_i == CMD_CTRL);
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

    // The final payload byte is still on data_i when the command completes, so splice it in.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            w_bytes[i] = r_buf[i];
            if (r_state == S_PAYLOAD && CNT_W'(i) == r_cnt) w_bytes[i] = rx_if.data_i;
        end
    end

    always_comb begin
        w_freq = '0;
        w_dpat = '0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            w_freq[i*8 +: 8] = w_bytes[i];
            w_dpat[i*8 +: 8] = w_bytes[i+1];
        end
    end

    assign w_ch          = w_bytes[0];
    assign w_ch_in_range = int'(w_ch) < CH_NUM;
    assign w_ch_ok       = (r_cmd == CMD_DATA) ? w_ch_in_range :
                           (r_cmd == CMD_CTRL) ? (w_ch_in_range || w_ch == 8'hFF) : 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_apply      = 1'b0;
        w_err        = 1'b0;
        w_err_code   = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    if (w_known) begin
                        w_state_next = S_PAYLOAD;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = 3'd2;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_tick) begin
                    if (r_cnt == r_last) begin
`ifdef DECODER_CHECKSUM_EN
                        w_state_next = S_CHECK;
`else
                        w_state_next = S_IDLE;
                        if (w_ch_ok) begin
                            w_apply = 1'b1;
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = 3'd3;
                        end
`endif
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                    w_err_code   = 3'd1;
                end
            end
`ifdef DECODER_CHECKSUM_EN
            S_CHECK: begin
                if (w_tick) begin
                    w_state_next = S_IDLE;
                    if (rx_if.data_i != r_xor) begin
                        w_err      = 1'b1;
                        w_err_code = 3'd4;
                    end else if (!w_ch_ok) begin
                        w_err      = 1'b1;
                        w_err_code = 3'd3;
                    end else begin
                        w_apply = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                    w_err_code   = 3'd1;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (r_state == S_PAYLOAD && w_tick) r_buf[r_cnt] <= rx_if.data_i;
`ifdef DECODER_CHECKSUM_EN
        if (r_state == S_IDLE && w_tick)         r_xor <= rx_if.data_i;
        else if (r_state == S_PAYLOAD && w_tick) r_xor <= r_xor ^ rx_if.data_i;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= S_IDLE;
            r_cmd            <= 8'h00;
            r_cnt            <= '0;
            r_last           <= '0;
            r_tmo            <= '0;
            output_pattern_o <= '0;
            freq_pattern_o   <= '0;
            sel_out_o        <= '0;
            broadcast_o      <= 1'b0;
            mode_o           <= 1'b0;
            enable_o         <= 1'b0;
            stop_o           <= 1'b0;
            slow_period_o    <= 8'h00;
            fast_period_o    <= 8'h00;
            cmd_o            <= 8'h00;
            done_tick_o      <= 1'b0;
            err_tick_o       <= 1'b0;
            err_code_o       <= 3'd0;
        end else begin
            r_state     <= w_state_next;
            done_tick_o <= w_apply;
            err_tick_o  <= w_err;
            if (w_err) err_code_o <= w_err_code;

            if (w_tick || w_state_next == S_IDLE) r_tmo <= '0;
            else                                  r_tmo <= r_tmo + TMO_W'(1);

            if (r_state == S_IDLE && w_tick && w_known) begin
                r_cmd  <= rx_if.data_i;
                r_last <= payload_last(rx_if.data_i);
                r_cnt  <= '0;
            end else if (r_state == S_PAYLOAD && w_tick && r_cnt != r_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_apply) begin
                cmd_o <= r_cmd;
                if (r_cmd == CMD_PERIOD) begin
                    slow_period_o <= w_bytes[0];
                    fast_period_o <= w_bytes[1];
                end else if (r_cmd == CMD_FREQ) begin
                    freq_pattern_o <= w_freq;
                end else if (r_cmd == CMD_DATA) begin
                    output_pattern_o <= w_dpat;
                    sel_out_o        <= w_ch[SEL_W-1:0];
                    broadcast_o      <= 1'b0;
                end else if (r_cmd == CMD_CTRL) begin
                    stop_o   <= w_bytes[1][2];
                    mode_o   <= w_bytes[1][1];
                    enable_o <= w_bytes[1][0];
                    if (w_ch == 8'hFF) begin
                        broadcast_o <= 1'b1;
                    end else begin
                        broadcast_o <= 1'b0;
                        sel_out_o   <= w_ch[SEL_W-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: vector table plus multi-cycle corner sequences.
module tb_uart_cmd_decoder;

    localparam int T = 40;
`ifdef DECODER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] output_pattern_o, freq_pattern_o;
    logic [3:0]  sel_out_o;
    logic        broadcast_o, mode_o, enable_o, stop_o;
    logic [7:0]  slow_period_o, fast_period_o, cmd_o;
    logic        done_tick_o, err_tick_o;
    logic [2:0]  err_code_o;

    uart_cmd_decoder_if rx ();

    uart_cmd_decoder #(.DATA_BIT(32), .CH_NUM(16), .TIMEOUT_CYC(T)) dut (
        .clk_i(clk), .rst_i(rst), .rx_if(rx),
        .output_pattern_o(output_pattern_o), .freq_pattern_o(freq_pattern_o),
        .sel_out_o(sel_out_o), .broadcast_o(broadcast_o), .mode_o(mode_o),
        .enable_o(enable_o), .stop_o(stop_o), .slow_period_o(slow_period_o),
        .fast_period_o(fast_period_o), .cmd_o(cmd_o), .done_tick_o(done_tick_o),
        .err_tick_o(err_tick_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] b;
        int          n;
        bit          ck;
        bit          done;
        bit          err;
        logic [2:0]  code;
        logic [31:0] pat;
        logic [31:0] freq;
        logic [3:0]  sel;
        bit          bc;
        logic [2:0]  ctl;
        logic [7:0]  slow;
        logic [7:0]  fast;
        logic [7:0]  cmd;
    } vec_t;

    vec_t vecs [12];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   early;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive n bytes back-to-back; optionally append XOR checksum seeded with 'seed'.
    task automatic send(input logic [63:0] b, input int n, input bit ck, input logic [7:0] seed);
        logic [7:0] x;
        logic [7:0] by;
        int         tot;
        x     = seed;
        early = 1'b0;
        tot   = ck ? n + 1 : n;
        for (int i = 0; i < tot; i++) begin
            by = (i < n) ? b[i*8 +: 8] : x;
            x  = x ^ by;
            if (i > 0 && (done_tick_o || err_tick_o)) early = 1'b1;
            rx.data_i         = by;
            rx.rx_done_tick_i = 1'b1;
            @(posedge clk);
            #1;
        end
        rx.rx_done_tick_i = 1'b0;
        rx.data_i         = 8'h00;
    endtask

    task automatic check_row(input vec_t v);
        chk({v.name, ".early"}, 64'(early), 64'd0);
        chk({v.name, ".done"},  64'(done_tick_o), 64'(v.done));
        chk({v.name, ".err"},   64'(err_tick_o), 64'(v.err));
        chk({v.name, ".code"},  64'(err_code_o), 64'(v.code));
        chk({v.name, ".pat"},   64'(output_pattern_o), 64'(v.pat));
        chk({v.name, ".freq"},  64'(freq_pattern_o), 64'(v.freq));
        chk({v.name, ".sel"},   64'(sel_out_o), 64'(v.sel));
        chk({v.name, ".bc"},    64'(broadcast_o), 64'(v.bc));
        chk({v.name, ".ctl"},   64'({stop_o, mode_o, enable_o}), 64'(v.ctl));
        chk({v.name, ".slow"},  64'(slow_period_o), 64'(v.slow));
        chk({v.name, ".fast"},  64'(fast_period_o), 64'(v.fast));
        chk({v.name, ".cmd"},   64'(cmd_o), 64'(v.cmd));
        @(posedge clk);
        #1;
        chk({v.name, ".pulse_end"}, 64'({done_tick_o, err_tick_o}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  err_seen;

        //          name          bytes                       n  ck done err code pat           freq          sel  bc ctl     slow   fast   cmd
        vecs[0]  = '{"period",     64'h051403,                 3, 1, 1, 0, 3'd0, 32'h0,        32'h0,        4'h0, 0, 3'b000, 8'h14, 8'h05, 8'h03};
        vecs[1]  = '{"freq",       64'h1122334402,             5, 1, 1, 0, 3'd0, 32'h0,        32'h11223344, 4'h0, 0, 3'b000, 8'h14, 8'h05, 8'h02};
        vecs[2]  = '{"data",       64'hBBCCDDEE0501,           6, 1, 1, 0, 3'd0, 32'hBBCCDDEE, 32'h11223344, 4'h5, 0, 3'b000, 8'h14, 8'h05, 8'h01};
        vecs[3]  = '{"ctrl_ch",    64'h030504,                 3, 1, 1, 0, 3'd0, 32'hBBCCDDEE, 32'h11223344, 4'h5, 0, 3'b011, 8'h14, 8'h05, 8'h04};
        vecs[4]  = '{"ctrl_bc",    64'h05FF04,                 3, 1, 1, 0, 3'd0, 32'hBBCCDDEE, 32'h11223344, 4'h5, 1, 3'b101, 8'h14, 8'h05, 8'h04};
        vecs[5]  = '{"data_badch", 64'hDDCCBBAA1001,           6, 1, 0, 1, 3'd3, 32'hBBCCDDEE, 32'h11223344, 4'h5, 1, 3'b101, 8'h14, 8'h05, 8'h04};
        vecs[6]  = '{"unknown",    64'h7F,                     1, 0, 0, 1, 3'd2, 32'hBBCCDDEE, 32'h11223344, 4'h5, 1, 3'b101, 8'h14, 8'h05, 8'h04};
        vecs[7]  = '{"ctrl_badch", 64'h011004,                 3, 1, 0, 1, 3'd3, 32'hBBCCDDEE, 32'h11223344, 4'h5, 1, 3'b101, 8'h14, 8'h05, 8'h04};
        vecs[8]  = '{"data_ff",    64'h44332211FF01,           6, 1, 0, 1, 3'd3, 32'hBBCCDDEE, 32'h11223344, 4'h5, 1, 3'b101, 8'h14, 8'h05, 8'h04};
        vecs[9]  = '{"ctrl_ch15",  64'h020F04,                 3, 1, 1, 0, 3'd3, 32'hBBCCDDEE, 32'h11223344, 4'hF, 0, 3'b010, 8'h14, 8'h05, 8'h04};
        vecs[10] = '{"data_ch3",   64'h123456780301,           6, 1, 1, 0, 3'd3, 32'h12345678, 32'h11223344, 4'h3, 0, 3'b010, 8'h14, 8'h05, 8'h01};
        vecs[11] = '{"period_edge",64'h00FF03,                 3, 1, 1, 0, 3'd3, 32'h12345678, 32'h11223344, 4'h3, 0, 3'b010, 8'hFF, 8'h00, 8'h03};

        rx.data_i         = 8'h00;
        rx.rx_done_tick_i = 1'b0;
        rst               = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset.pat",  64'(output_pattern_o), 64'd0);
        chk("reset.freq", 64'(freq_pattern_o), 64'd0);
        chk("reset.ctl",  64'({sel_out_o, broadcast_o, stop_o, mode_o, enable_o}), 64'd0);
        chk("reset.per",  64'({slow_period_o, fast_period_o, cmd_o}), 64'd0);
        chk("reset.tick", 64'({done_tick_o, err_tick_o, err_code_o}), 64'd0);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].b, vecs[i].n, vecs[i].ck && CK, 8'h00);
            check_row(vecs[i]);
        end

        // Back-to-back commands: second code byte arrives while done_tick_o is high.
        send(64'h072103, 3, CK, 8'h00);
        chk("b2b.first_done", 64'(done_tick_o), 64'd1);
        send(64'h082203, 3, CK, 8'h00);
        chk("b2b.early", 64'(early), 64'd0);
        chk("b2b.second_done", 64'(done_tick_o), 64'd1);
        chk("b2b.periods", 64'({slow_period_o, fast_period_o}), 64'h2208);
        @(posedge clk);
        #1;

        // Inter-byte timeout, then a complete command recovers.
        send(64'h4402, 2, 1'b0, 8'h00);
        cnt = 0;
        while (!err_tick_o && cnt < 3 * T) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("tmo.latency", 64'(cnt), 64'(T));
        chk("tmo.code", 64'(err_code_o), 64'd1);
        chk("tmo.freq_kept", 64'(freq_pattern_o), 64'h11223344);
        @(posedge clk);
        #1;
        send(64'h4433221102, 5, CK, 8'h00);
        chk("tmo.recover_done", 64'(done_tick_o), 64'd1);
        chk("tmo.recover_freq", 64'(freq_pattern_o), 64'h44332211);
        chk("tmo.code_held", 64'(err_code_o), 64'd1);
        @(posedge clk);
        #1;

        // A tick landing on the timeout cycle wins.
        send(64'h4402, 2, 1'b0, 8'h00);
        err_seen = 1'b0;
        repeat (T - 1) begin
            @(posedge clk);
            #1;
            if (err_tick_o) err_seen = 1'b1;
        end
        send(64'h112233, 3, CK, 8'h46);
        chk("tie.no_err", 64'({err_seen, early, err_tick_o}), 64'd0);
        chk("tie.done", 64'(done_tick_o), 64'd1);
        chk("tie.freq", 64'(freq_pattern_o), 64'h11223344);
        @(posedge clk);
        #1;

        // Reset in the middle of a DATA command.
        send(64'hAA0701, 3, 1'b0, 8'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.pat_freq", 64'({output_pattern_o, freq_pattern_o}), 64'd0);
        chk("rst.ctl", 64'({sel_out_o, broadcast_o, stop_o, mode_o, enable_o}), 64'd0);
        chk("rst.per", 64'({slow_period_o, fast_period_o, cmd_o, err_code_o}), 64'd0);
        send(64'h051403, 3, CK, 8'h00);
        chk("rst.next_done", 64'(done_tick_o), 64'd1);
        chk("rst.next_per", 64'({slow_period_o, fast_period_o, cmd_o}), 64'h140503);
        @(posedge clk);
        #1;

`ifdef DECODER_CHECKSUM_EN
        send(64'h12051403, 4, 1'b0, 8'h00);
        chk("ck.good_done", 64'(done_tick_o), 64'd1);
        chk("ck.good_per", 64'({slow_period_o, fast_period_o}), 64'h1405);
        @(posedge clk);
        #1;
        send(64'h13776603, 4, 1'b0, 8'h00);
        chk("ck.bad_err", 64'({done_tick_o, err_tick_o}), 64'd1);
        chk("ck.bad_code", 64'(err_code_o), 64'd4);
        chk("ck.bad_per", 64'({slow_period_o, fast_period_o}), 64'h1405);
        @(posedge clk);
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Parametrised successor of the UART command decoder. Consumes the byte stream from the UART receiver (data byte plus rx_done tick) and assembles multi-byte commands: period, frequency pattern, per-channel data pattern and per-channel control. Generalises width and channel count, and adds a broadcast control command, an inter-byte timeout, and error reporting. It sits between the UART RX and the multi-channel serial-out channels.

Parameters:
DATA_BIT, 32, pattern width in bits; must be a multiple of 8. PAYLOAD_BYTES = DATA_BIT/8, sent LSB byte first.
CH_NUM, 16, number of output channels (2..255); SEL_W = $clog2(CH_NUM).
TIMEOUT_CYC, 100000, idle clk_i cycles allowed between bytes of one command before abort.
CMD_DATA, 8'h01 / CMD_FREQ, 8'h02 / CMD_PERIOD, 8'h03 / CMD_CTRL, 8'h04: command codes.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
data_i  in  8  received UART byte, valid when rx_done_tick_i=1
rx_done_tick_i  in  1  one-cycle byte-valid strobe
output_pattern_o  out  DATA_BIT  data pattern of last CMD_DATA
freq_pattern_o  out  DATA_BIT  frequency-select pattern
sel_out_o  out  SEL_W  target channel of last DATA/CTRL command
broadcast_o  out  1  1 = last CTRL command targets all channels
mode_o  out  1  ctrl bit1: 0 one-shot, 1 repeat
enable_o  out  1  ctrl bit0
stop_o  out  1  ctrl bit2
slow_period_o  out  8  slow bit period
fast_period_o  out  8  fast bit period
cmd_o  out  8  code of last completed command
done_tick_o  out  1  one-cycle pulse: command applied
err_tick_o  out  1  one-cycle pulse: command rejected
err_code_o  out  3  1 timeout, 2 unknown cmd, 3 bad channel, 4 checksum; holds until next error

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0. A reset mid-command discards the partial command.
- FSM: IDLE -> PAYLOAD on a tick whose byte is a known code. Payload length: PERIOD 2 (slow, fast); FREQ PAYLOAD_BYTES; DATA 1+PAYLOAD_BYTES (channel, then pattern); CTRL 2 (channel, ctrl byte). PAYLOAD -> (CHECK if checksum) -> IDLE.
- Unknown code in IDLE: err_tick_o with code 2, remain IDLE.
- Payload is collected into shadow registers. Outputs change only at completion.
- Latency: the last byte's tick at cycle N updates outputs, cmd_o and done_tick_o at N+1. Outputs change on no other cycle.
- Channel byte 8'hFF on CTRL: broadcast_o=1, sel_out_o unchanged.
- On DATA, or on CTRL with channel < CH_NUM: broadcast_o=0 and sel_out_o=channel.
- Any other channel value (including 8'hFF on DATA): the whole payload is still consumed, then err_tick_o with code 3 at N+1, no output update, no done_tick_o.
- Timeout counter clears on every tick and counts in non-IDLE states. If it reaches TIMEOUT_CYC-1: err_tick_o with code 1, return to IDLE, shadow discarded.
- If a tick and the timeout occur in the same cycle, the tick wins and the counter clears.
- done_tick_o and err_tick_o are never high together. rx_done_tick_i pulses may be back-to-back.
- A tick arriving in the same cycle as done_tick_o is accepted as the next command byte.

Optional Feature:
Macro DECODER_CHECKSUM_EN.
- Defined: each command carries one extra trailing byte equal to the XOR of the command code and all payload bytes. FSM passes through CHECK. Mismatch gives err_tick_o with code 4 and no update. Latency is measured from the checksum byte.
- Undefined: no CHECK state, no trailing byte, code 4 never produced.

Test Plan:
- Reset, then PERIOD 03,14,05 -> slow_period_o=8'h14, fast_period_o=8'h05, cmd_o=8'h03, done_tick_o one cycle after the last tick.
- FREQ 02,44,33,22,11 -> freq_pattern_o=32'h11223344. DATA 01,05,EE,DD,CC,BB -> sel_out_o=5, output_pattern_o=32'hBBCCDDEE.
- CTRL 04,05,03 -> mode_o=1, enable_o=1, stop_o=0, broadcast_o=0. CTRL 04,FF,05 -> broadcast_o=1, stop_o=1, enable_o=1, sel_out_o stays 5.
- DATA 01,10,... with CH_NUM=16 -> err_code_o=3, output_pattern_o unchanged. Byte 7F in IDLE -> err_code_o=2.
- FREQ 02,44 then silence for TIMEOUT_CYC cycles -> err_code_o=1. A following full FREQ command then succeeds. Asserting rst_i mid-DATA -> all outputs 0, the next command decodes correctly.
- With DECODER_CHECKSUM_EN: PERIOD 03,14,05,12 is accepted; PERIOD 03,14,05,13 gives err_code_o=4 and periods unchanged. Also run with DATA_BIT=64, CH_NUM=4.
